// File: rtl/op_pkg.sv
// Shared types for the operand arbiter: opcode encoding and sequencer states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package op_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request bit at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is taken.
// Ports: req[N] requests, ptr start index, grant_valid any request, grant_idx winner.
module rr_picker #(
  parameter int  N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx
);

  // Index reached by stepping k places forward from p, wrapping at N.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Scan in priority order starting at ptr; the first hit is kept.
    for (int k = 0; k < N; k++) begin
      if (!grant_valid && req[wrap_add(ptr, k)]) begin
        grant_valid = 1'b1;
        grant_idx   = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/op_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/ADD unit among N_REQ requesters.
// Latency: accept at cycle T, rsp_valid at T+2; at most one transaction in flight.
// Backpressure: rsp_ready low holds the response indefinitely; no new accept until it drains.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_a/req_b/req_op per requester;
//        rsp_valid/rsp_ready handshake carrying rsp_data and the owning requester rsp_id.
module op_arbiter
  import op_pkg::*;
#(
  parameter int  N_REQ = 3,
  parameter int  WIDTH = 16,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [WIDTH-1:0]   req_a [N_REQ],
  input  logic [WIDTH-1:0]   req_b [N_REQ],
  input  op_t                req_op [N_REQ],
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [IDW-1:0]     rsp_id
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] a_q, b_q;
  op_t              op_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] alu_res;
  logic             grant_valid;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic             rsp_done;

  rr_picker #(.N(N_REQ)) u_picker (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake strobes. rsp_ready only matters in RESP, where
  // rsp_valid is always high, so it is naturally ignored elsewhere.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid && !reset) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Carry out of the ADD is dropped by the WIDTH-bit result.
  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_ADD:  alu_res = a_q + b_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_AND;
      id_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
    end else begin
      if (accept) begin
        a_q  <= req_a[grant_idx];
        b_q  <= req_b[grant_idx];
        op_q <= req_op[grant_idx];
        id_q <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_data  <= alu_res;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        // The requester just served drops to lowest priority.
        ptr_q     <= (id_q == IDW'(N_REQ - 1)) ? '0 : id_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_op_arbiter.sv
// Self-checking bench for op_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_op_arbiter;
  import op_pkg::*;

  localparam int N = 3;
  localparam int W = 16;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] req_valid, req_ready;
  logic [W-1:0] req_a [N];
  logic [W-1:0] req_b [N];
  op_t          req_op [N];
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0]   rsp_id;

  op_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  // Stimulus staging, applied to the DUT at each falling edge.
  logic         s_reset;
  logic [N-1:0] s_valid;
  logic [W-1:0] s_a [N];
  logic [W-1:0] s_b [N];
  logic [1:0]   s_op [N];
  logic         s_rdy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: one transaction in flight, described by its accept time.
  bit       m_busy    = 1'b0;
  int       m_tacc    = 0;
  int       m_id      = 0;
  int       m_ptr     = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_shown_d = '0;
  int       m_shown_id = 0;

  // Observed DUT events.
  int           obs_acc_id [$];
  int           obs_acc_c  [$];
  logic [W-1:0] obs_rsp_d  [$];
  int           obs_rsp_id [$];
  int           obs_rsp_c  [$];
  logic         last_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return W'((int'(a) + int'(b)) % 65536);
    endcase
  endfunction

  task automatic cycle();
    int           w;
    int           idx;
    logic [N-1:0] er;
    logic         ev;
    @(negedge clk);
    reset     = s_reset;
    req_valid = s_valid;
    rsp_ready = s_rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i]  = s_a[i];
      req_b[i]  = s_b[i];
      req_op[i] = op_t'(s_op[i]);
    end
    #1;
    w  = rr_pick(s_valid, m_ptr);
    er = '0;
    if (!s_reset && !m_busy && w >= 0) er[w] = 1'b1;
    ev = m_busy && (cyc >= m_tacc + 2);
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_data",  rsp_data,  m_shown_d);
    chk("rsp_id",    rsp_id,    m_shown_id);
    last_vld = rsp_valid;
    if (!s_reset && req_ready != '0) begin
      idx = -1;
      for (int k = 0; k < N; k++) if (req_ready[k]) idx = k;
      obs_acc_id.push_back(idx);
      obs_acc_c.push_back(cyc);
    end
    if (!s_reset && rsp_valid === 1'b1 && s_rdy) begin
      obs_rsp_d.push_back(rsp_data);
      obs_rsp_id.push_back(int'(rsp_id));
      obs_rsp_c.push_back(cyc);
    end
    // Advance the model across the coming rising edge.
    if (s_reset) begin
      m_busy = 1'b0; m_ptr = 0; m_shown_d = '0; m_shown_id = 0;
    end else if (!m_busy && w >= 0) begin
      m_busy = 1'b1; m_tacc = cyc; m_id = w;
      m_res  = ref_op(s_a[w], s_b[w], s_op[w]);
    end else if (m_busy && cyc == m_tacc + 1) begin
      m_shown_d = m_res; m_shown_id = m_id;
    end else if (ev && s_rdy) begin
      m_busy = 1'b0; m_ptr = (m_id + 1) % N;
    end
    cyc++;
  endtask

  task automatic run_rsp(input int budget);
    int n0;
    n0 = obs_rsp_d.size();
    for (int i = 0; i < budget && obs_rsp_d.size() == n0; i++) cycle();
    chk("rsp_arrived", obs_rsp_d.size(), n0 + 1);
  endtask

  task automatic wait_vld(input int budget);
    last_vld = 1'b0;
    for (int i = 0; i < budget && !last_vld; i++) cycle();
    chk("rsp_valid_rose", last_vld, 1'b1);
  endtask

  task automatic drain();
    s_valid = '0;
    s_rdy   = 1'b1;
    for (int i = 0; i < 10 && m_busy; i++) cycle();
    cycle();
  endtask

  int k0, r0, hc;
  int exp_order [4] = '{0, 1, 2, 0};

  initial begin
    s_reset = 1'b1; s_valid = '0; s_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_a[i] = '0; s_b[i] = '0; s_op[i] = 2'd0;
      req_a[i] = '0; req_b[i] = '0; req_op[i] = OP_AND;
    end
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    cycle();                       // reset-state checks
    s_reset = 1'b0;

    // Single AND request from requester 1.
    s_valid = 3'b010; s_a[1] = 16'h00FF; s_b[1] = 16'h0F0F; s_op[1] = 2'd0; s_rdy = 1'b1;
    run_rsp(10);
    s_valid = '0;
    if (obs_rsp_d.size() > 0 && obs_acc_c.size() > 0) begin
      chk("and_data", obs_rsp_d[$], 16'h000F);
      chk("and_id",   obs_rsp_id[$], 1);
      chk("and_lat",  obs_rsp_c[$] - obs_acc_c[$], 2);
    end
    cycle();

    // ADD wraps modulo 2^16.
    s_valid = 3'b001; s_a[0] = 16'hFFFF; s_b[0] = 16'h0002; s_op[0] = 2'd3;
    run_rsp(10);
    s_valid = '0;
    if (obs_rsp_d.size() > 0) chk("add_wrap", obs_rsp_d[$], 16'h0001);
    cycle();

    // Round-robin with all three continuously valid.
    s_reset = 1'b1; cycle(); s_reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      s_a[i] = W'($urandom); s_b[i] = W'($urandom); s_op[i] = 2'($urandom_range(0, 3));
    end
    s_valid = 3'b111;
    k0 = obs_acc_id.size();
    repeat (12) cycle();
    s_valid = '0;
    chk("rr_count", obs_acc_id.size() - k0, 4);
    if (obs_acc_id.size() >= k0 + 4) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("rr_grant%0d", j), obs_acc_id[k0 + j], exp_order[j]);
      for (int j = 1; j < 4; j++)
        chk($sformatf("rr_gap%0d", j), obs_acc_c[k0 + j] - obs_acc_c[k0 + j - 1], 3);
    end
    drain();

    // Back-pressure: XOR response held for 5 cycles while others wait.
    s_valid = 3'b100; s_a[2] = 16'hAAAA; s_b[2] = 16'h5555; s_op[2] = 2'd2; s_rdy = 1'b0;
    wait_vld(10);
    s_valid = 3'b011;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      chk("bp_data", rsp_data, 16'hFFFF);
      chk("bp_id",   rsp_id,   2);
      chk("bp_rdy",  req_ready, 3'b000);
    end
    s_rdy = 1'b1;
    r0 = obs_rsp_d.size();
    cycle();
    hc = cyc - 1;
    chk("bp_release", obs_rsp_d.size(), r0 + 1);
    cycle();
    if (obs_acc_c.size() > 0) begin
      chk("bp_next_acc_cyc", obs_acc_c[$], hc + 1);
      chk("bp_next_acc_id",  obs_acc_id[$], 0);
    end
    drain();

    // Reset while the response is pending.
    s_valid = 3'b001; s_op[0] = 2'd1; s_a[0] = 16'h1234; s_b[0] = 16'h8001; s_rdy = 1'b0;
    wait_vld(10);
    r0 = obs_rsp_d.size();
    s_valid = '0; s_reset = 1'b1;
    cycle();
    s_reset = 1'b0; s_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rst_vld",  rsp_valid, 1'b0);
    chk("rst_data", rsp_data,  16'h0000);
    chk("rst_id",   rsp_id,    2'd0);
    s_valid = 3'b111;
    cycle();
    chk("rst_grant", req_ready, 3'b001);
    chk("rst_norsp", obs_rsp_d.size(), r0);
    drain();

    // Withdrawn pulse from requester 2 while busy.
    s_valid = 3'b001; s_rdy = 1'b0;
    wait_vld(10);
    k0 = obs_acc_id.size(); r0 = obs_rsp_d.size();
    s_valid = 3'b100; cycle();
    s_valid = 3'b000; cycle();
    s_rdy = 1'b1;
    repeat (4) cycle();
    chk("wd_no_acc", obs_acc_id.size(), k0);
    chk("wd_one_rsp", obs_rsp_d.size(), r0 + 1);
    if (obs_rsp_id.size() > 0) chk("wd_rsp_id", obs_rsp_id[$], 0);

    // Randomized traffic.
    for (int t = 0; t < 1500; t++) begin
      s_reset = ($urandom_range(0, 199) == 0);
      s_valid = N'($urandom_range(0, 7));
      s_rdy   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        s_a[i] = W'($urandom); s_b[i] = W'($urandom); s_op[i] = 2'($urandom_range(0, 3));
      end
      cycle();
    end
    s_reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
